// File: rtl/svf_coef_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | svf_coef_sequencer: F/Q1 coefficient sequencer for the SVF. Sweeps F      |
// | exponentially between limits, steps Q1 presets on button presses, and     |
// | applies changes on lrclk sample boundaries.                               |
// | Option macro: SVF_SEQ_LINEAR_SWEEP_EN (constant LIN_STEP sweep step).      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module svf_coef_sequencer #(
  parameter int FWIDTH     = 20,
  parameter int F_INIT     = 68568,
  parameter int F_MIN      = 686,
  parameter int F_MAX      = 524288,
  parameter int STEP_SHIFT = 6,
  parameter int LIN_STEP   = 256,
  parameter int DIV        = 48,
  parameter int DEBOUNCE   = 65536,
  parameter int Q1_0       = 370727,
  parameter int Q1_1       = 262144,
  parameter int Q1_2       = 131072,
  parameter int Q1_3       = 52429
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lrclk,
  input  logic              button,
  input  logic              sweep_en,
  output logic [FWIDTH-1:0] F,
  output logic [FWIDTH-1:0] Q1,
  output logic              coef_strobe,
  output logic [1:0]        q_index,
  output logic              dir
);

  localparam int c_FW1  = FWIDTH + 1;
  localparam int c_DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int c_DB_W  = $clog2(DEBOUNCE + 1);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV - 1);
  localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE - 1);

  localparam logic [1:0] c_ST_HOLD = 2'd0;
  localparam logic [1:0] c_ST_UP   = 2'd1;
  localparam logic [1:0] c_ST_DOWN = 2'd2;

  logic r_lr_s1, r_lr_s2, r_lr_d, r_tick;
  logic r_btn_s1, r_btn_s2, r_db_pressed, r_q_pending;
  logic [c_DB_W-1:0]  r_db_cnt;
  logic [c_DIV_W-1:0] r_div_cnt;
  logic [1:0]         r_state, w_state_next;
  logic [FWIDTH-1:0]  r_f, r_q1, w_f_next, w_q1_next;
  logic [1:0]         r_q_index, w_q_idx_next;
  logic               r_dir, w_dir_next, r_strobe;
  logic               w_press, w_q_upd, w_sweep_tick, w_leave, w_down, w_upd;
  logic [c_FW1-1:0]   w_step, w_f_ext, w_f_add, w_f_sub;
  logic               w_clamp_hi, w_clamp_lo;

  // Synchronizers, lrclk rising-edge tick, and two-sided button debouncer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lr_s1      <= 1'b0;
      r_lr_s2      <= 1'b0;
      r_lr_d       <= 1'b0;
      r_tick       <= 1'b0;
      r_btn_s1     <= 1'b1;
      r_btn_s2     <= 1'b1;
      r_db_pressed <= 1'b0;
      r_db_cnt     <= '0;
      r_q_pending  <= 1'b0;
    end else begin
      r_lr_s1  <= lrclk;
      r_lr_s2  <= r_lr_s1;
      r_lr_d   <= r_lr_s2;
      r_tick   <= r_lr_s2 & ~r_lr_d;
      r_btn_s1 <= button;
      r_btn_s2 <= r_btn_s1;
      if (~r_btn_s2 != r_db_pressed) begin
        if (r_db_cnt == c_DB_LAST) begin
          r_db_pressed <= ~r_db_pressed;
          r_db_cnt     <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + c_DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
      if (w_press)
        r_q_pending <= 1'b1;
      else if (r_tick)
        r_q_pending <= 1'b0;
    end
  end

  assign w_press = ~r_btn_s2 & ~r_db_pressed & (r_db_cnt == c_DB_LAST);
  assign w_q_upd = r_tick & r_q_pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= c_ST_HOLD;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (r_tick) begin
      if (!sweep_en)
        w_state_next = c_ST_HOLD;
      else
        w_state_next = w_dir_next ? c_ST_DOWN : c_ST_UP;
    end
  end

  // The tick that leaves HOLD already counts toward the first update
  always_comb begin
    w_sweep_tick = r_tick & sweep_en;
    w_leave      = r_tick & ~sweep_en & (r_state != c_ST_HOLD);
    w_down       = (r_state == c_ST_DOWN) || ((r_state == c_ST_HOLD) && r_dir);
    w_upd        = w_sweep_tick & (r_div_cnt == c_DIV_LAST);
  end

  always_comb begin
    w_f_ext = {1'b0, r_f};
`ifdef SVF_SEQ_LINEAR_SWEEP_EN
    w_step = c_FW1'(LIN_STEP);
`else
    w_step = w_f_ext >> STEP_SHIFT;
    if (w_step == '0)
      w_step = c_FW1'(1);
`endif
    w_f_add    = w_f_ext + w_step;
    w_f_sub    = w_f_ext - w_step;
    w_clamp_hi = (w_f_add >= c_FW1'(F_MAX));
    w_clamp_lo = (w_f_ext <= (c_FW1'(F_MIN) + w_step));
    w_f_next   = r_f;
    w_dir_next = r_dir;
    if (w_upd) begin
      if (!w_down) begin
        if (w_clamp_hi) begin
          w_f_next   = FWIDTH'(F_MAX);
          w_dir_next = 1'b1;
        end else begin
          w_f_next = w_f_add[FWIDTH-1:0];
        end
      end else begin
        if (w_clamp_lo) begin
          w_f_next   = FWIDTH'(F_MIN);
          w_dir_next = 1'b0;
        end else begin
          w_f_next = w_f_sub[FWIDTH-1:0];
        end
      end
    end
  end

  always_comb begin
    w_q_idx_next = r_q_index + 2'd1;
    case (w_q_idx_next)
      2'd0:    w_q1_next = FWIDTH'(Q1_0);
      2'd1:    w_q1_next = FWIDTH'(Q1_1);
      2'd2:    w_q1_next = FWIDTH'(Q1_2);
      default: w_q1_next = FWIDTH'(Q1_3);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_f       <= FWIDTH'(F_INIT);
      r_q1      <= FWIDTH'(Q1_0);
      r_q_index <= 2'd0;
      r_dir     <= 1'b0;
      r_strobe  <= 1'b0;
      r_div_cnt <= '0;
    end else begin
      r_f      <= w_f_next;
      r_dir    <= w_dir_next;
      r_strobe <= (w_f_next != r_f) | (w_q_upd & (w_q1_next != r_q1));
      if (w_q_upd) begin
        r_q_index <= w_q_idx_next;
        r_q1      <= w_q1_next;
      end
      if (w_leave)
        r_div_cnt <= '0;
      else if (w_sweep_tick)
        r_div_cnt <= (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + c_DIV_W'(1);
    end
  end

  assign F           = r_f;
  assign Q1          = r_q1;
  assign q_index     = r_q_index;
  assign dir         = r_dir;
  assign coef_strobe = r_strobe;

endmodule
`default_nettype wire

// File: doc/svf_coef_sequencer.md
# svf_coef_sequencer

Coefficient sequencer for the state-variable (parametric) filter: generates the frequency word `F` and damping word `Q1`, sweeping `F` exponentially between two limits and stepping `Q1` through four presets on each user-button press. Coefficient changes are applied only on sample boundaries, derived from the codec LR clock, so the filter never sees a coefficient change mid-sample. The block sits between the board button/LR clock and the filter's `F`/`Q1` inputs.

## Interface
- `FWIDTH`, 20: width of `F` and `Q1`. `F` is unsigned 1.19 fixed point; `Q1` is unsigned 2.18 fixed point.
- `F_INIT`, 68568: reset value of `F` (about 1 kHz at 48 kHz).
- `F_MIN`, 686: lower sweep limit (about 10 Hz).
- `F_MAX`, 524288: upper sweep limit (about 8 kHz).
- `STEP_SHIFT`, 6: exponential step size, `step = F >> STEP_SHIFT`.
- `LIN_STEP`, 256: step size when the linear-sweep option is compiled in.
- `DIV`, 48: sample ticks per sweep update (1 ms).
- `DEBOUNCE`, 65536: consecutive stable clk cycles needed to accept a button level.
- `Q1_0`, `Q1_1`, `Q1_2`, `Q1_3`: 370727, 262144, 131072, 52429 (Q = 0.707, 1, 2, 5).
- `clk`, in, 1: system clock. Must be at least 4× the `lrclk` frequency.
- `reset`, in, 1: asynchronous, active-low reset.
- `lrclk`, in, 1: codec LR clock, asynchronous to `clk`.
- `button`, in, 1: user button, active-low, asynchronous to `clk`.
- `sweep_en`, in, 1: 1 = sweep `F`, 0 = hold `F`.
- `F`, out, FWIDTH: filter frequency coefficient.
- `Q1`, out, FWIDTH: filter damping coefficient.
- `coef_strobe`, out, 1: one-cycle pulse in the cycle new coefficients appear.
- `q_index`, out, 2: index of the active Q preset.
- `dir`, out, 1: sweep direction, 0 = up, 1 = down.

## Operation
- `lrclk` passes through a 2-FF synchronizer and a rising-edge detector. Each detected edge produces a one-cycle `tick`.
- `button` passes through a 2-FF synchronizer and a debouncer:
  - A press registers after `DEBOUNCE` consecutive low cycles.
  - It then re-arms only after `DEBOUNCE` consecutive high cycles.
  - Each registered press sets `q_pending`.
- State machine states: HOLD, UP, DOWN.
  - HOLD → UP or DOWN, per `dir`, at a tick with `sweep_en`=1.
  - UP or DOWN → HOLD at a tick with `sweep_en`=0.
  - `sweep_en` is sampled only at ticks.
- Division counter:
  - Counts ticks only in UP and DOWN; cleared on entering HOLD.
  - At count `DIV`-1 it wraps to 0 and performs a sweep update.
- Sweep update, computed at FWIDTH+1 bits:
  - `step = F >> STEP_SHIFT`; a step of 0 is forced to 1.
  - UP: `next = F + step`. If `next >= F_MAX`, then `F = F_MAX` and `dir` ← 1.
  - DOWN: if `F <= F_MIN + step`, then `F = F_MIN` and `dir` ← 0; otherwise `F = F - step`.
- Q update: at a tick with `q_pending`=1:
  - `q_index` ← `q_index + 1` (wraps 3 → 0).
  - `Q1` ← preset for the new index.
  - `q_pending` is cleared.
  - Multiple presses between two ticks collapse to a single step.
- If an F update and a Q update fall on the same tick, both apply in the same cycle with a single strobe.
- `coef_strobe` asserts only when `F` or `Q1` actually changed.
- Reset values: `F`=`F_INIT`, `Q1`=`Q1_0`, `q_index`=0, `dir`=0, `coef_strobe`=0, state HOLD, counters cleared, `q_pending`=0, debouncer in released state.
- Reset asserted mid-operation returns all of the above asynchronously. A pending press is discarded.

## Timing
- `tick` asserts 3 clk cycles after the `lrclk` rising edge (2 sync stages + edge register).
- `F`, `Q1`, `q_index`, `dir` and `coef_strobe` are all registered. They update on the clk edge following `tick`, and `coef_strobe` is high for exactly that one cycle.
- Outputs are otherwise constant between ticks.
- Button latency: `DEBOUNCE`+2 cycles to set `q_pending`, then up to one sample period until the next tick.

## Configuration
- `SVF_SEQ_LINEAR_SWEEP_EN` defined: `step = LIN_STEP` (constant). Clamping rules are unchanged.
- Not defined: exponential step `F >> STEP_SHIFT` with a minimum of 1.

## Test plan
- Reset:
  - Release reset → `F`=68568, `Q1`=370727, `q_index`=0, `dir`=0, no strobe across 10 `lrclk` periods with `sweep_en`=0.
  - Assert reset mid-sweep → `F` returns to 68568 immediately.
- Sweep up: `DIV`=2, `sweep_en`=1 → after 2 ticks `F`=69639 (68568+1071), `coef_strobe` high for 1 cycle, 4 clk after the `lrclk` edge.
- Max clamp: `F_INIT`=520000, `DIV`=1:
  - First update: `F`=524288, `dir`=1.
  - Second update: `F`=516096.
- Min clamp: `F_INIT`=690, `dir` forced down via prior clamp, `DIV`=1 → step 10, `F`=686, `dir`=0, then 696.
- Button, with `DEBOUNCE`=16:
  - Low for 20 cycles → next tick `Q1`=262144, `q_index`=1.
  - Holding low for 1000 more cycles → no change.
  - Three more press/release pairs → wraps to `Q1`=370727, `q_index`=0.
- Simultaneous events: press lands in the same tick as a sweep update → `F` and `Q1` change in one cycle with a single strobe. Then set `sweep_en`=0 → `F` frozen and no strobes for 100 ticks.
